// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of ALU writeback, load issue/return, hazard query and register-file
// write signals shared between the write arbiter and its environment.
interface regfile_wb_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NR = 1 << AW;

    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          ld_issue;
    logic [AW-1:0] ld_rd;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] RX;
    logic [AW-1:0] RY;
    logic          stall_x;
    logic          stall_y;
    logic          WEN;
    logic [AW-1:0] RW;
    logic [DW-1:0] busW;
    logic [NR-1:0] pending;
    logic [CW-1:0] fifo_cnt;
    logic          err_waw;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_issue, ld_rd,
        input  mem_valid, mem_rd, mem_data, RX, RY,
        output mem_ready, stall_x, stall_y, WEN, RW, busW,
        output pending, fifo_cnt, err_waw
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_issue, ld_rd,
        output mem_valid, mem_rd, mem_data, RX, RY,
        input  mem_ready, stall_x, stall_y, WEN, RW, busW,
        input  pending, fifo_cnt, err_waw
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single write port arbiter for the register file: ALU results take priority,
// buffered load returns fill idle slots, and a pending bitmap flags RAW hazards.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NR = 1 << AW;

    logic [AW-1:0] r_fifo_rd   [DEPTH];
    logic [DW-1:0] r_fifo_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_wen;
    logic [AW-1:0] r_rw;
    logic [DW-1:0] r_busw;
    logic [NR-1:0] r_pending;
    logic          r_err_waw;

    logic          w_ready;
    logic          w_push;
    logic          w_alu_wr;
    logic          w_pop;
    logic [AW-1:0] w_head_rd;
    logic [DW-1:0] w_head_data;
    logic [NR-1:0] w_clr_mask;
    logic [NR-1:0] w_set_mask;
    logic [NR-1:0] w_pending_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_wen_nxt;
    logic [AW-1:0] w_rw_nxt;
    logic [DW-1:0] w_busw_nxt;
    logic          w_err_nxt;

    // Readiness looks at occupancy only, so a full FIFO refuses even on a pop cycle.
    assign w_ready     = !rst && (r_cnt < CW'(DEPTH));
    assign w_push      = bus.mem_valid && w_ready && (bus.mem_rd != {AW{1'b0}});
    assign w_alu_wr    = bus.alu_valid && (bus.alu_rd != {AW{1'b0}});
    assign w_pop       = !w_alu_wr && (r_cnt != {CW{1'b0}});
    assign w_head_rd   = r_fifo_rd[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    // Write-port selection, occupancy update and scoreboard next state.
    always_comb begin
        w_wen_nxt  = 1'b0;
        w_rw_nxt   = r_rw;
        w_busw_nxt = r_busw;
        w_clr_mask = {NR{1'b0}};
        w_set_mask = {NR{1'b0}};
        w_cnt_nxt  = r_cnt;
        w_err_nxt  = r_err_waw;
        if (w_alu_wr) begin
            w_wen_nxt  = 1'b1;
            w_rw_nxt   = bus.alu_rd;
            w_busw_nxt = bus.alu_data;
        end else if (w_pop) begin
            w_wen_nxt  = 1'b1;
            w_rw_nxt   = w_head_rd;
            w_busw_nxt = w_head_data;
            w_clr_mask = {{(NR-1){1'b0}}, 1'b1} << w_head_rd;
        end else begin
            w_wen_nxt  = 1'b0;
        end
        if (bus.ld_issue && (bus.ld_rd != {AW{1'b0}})) begin
            w_set_mask = {{(NR-1){1'b0}}, 1'b1} << bus.ld_rd;
        end else begin
            w_set_mask = {NR{1'b0}};
        end
        if (bus.alu_valid && r_pending[bus.alu_rd]) begin
            w_err_nxt = 1'b1;
        end else begin
            w_err_nxt = r_err_waw;
        end
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_cnt - CW'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
        // Set applied after clear so a same-cycle reissue keeps the bit.
        w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_nxt[0] = 1'b0;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= {PW{1'b0}};
            r_rptr <= {PW{1'b0}};
            r_cnt  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_rd[i]   <= {AW{1'b0}};
                r_fifo_data[i] <= {DW{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_fifo_rd[r_wptr]   <= bus.mem_rd;
                r_fifo_data[r_wptr] <= bus.mem_data;
                r_wptr              <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    // Registered write port, scoreboard and sticky WAW flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen     <= 1'b0;
            r_rw      <= {AW{1'b0}};
            r_busw    <= {DW{1'b0}};
            r_pending <= {NR{1'b0}};
            r_err_waw <= 1'b0;
        end else begin
            r_wen     <= w_wen_nxt;
            r_rw      <= w_rw_nxt;
            r_busw    <= w_busw_nxt;
            r_pending <= w_pending_nxt;
            r_err_waw <= w_err_nxt;
        end
    end

    assign bus.mem_ready = w_ready;
    assign bus.stall_x   = r_pending[bus.RX];
    assign bus.stall_y   = r_pending[bus.RY];
    assign bus.WEN       = r_wen;
    assign bus.RW        = r_rw;
    assign bus.busW      = r_busw;
    assign bus.pending   = r_pending;
    assign bus.fifo_cnt  = r_cnt;
    assign bus.err_waw   = r_err_waw;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus queues expected register
// writes, a negedge monitor retires them against WEN/RW/busW.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t ret_e[5];

    regfile_wb_arbiter_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

    regfile_wb_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data, input int at);
        exp_t e;
        e.rd = rd;
        e.data = data;
        e.at = at;
        sb_q.push_back(e);
    endtask

    // Monitor: every write seen on the port retires the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.WEN) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%h want no write (cycle %0d)",
                         bus.RW, bus.busW, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wr_rd", {27'd0, bus.RW}, {27'd0, mon_e.rd});
                chk("wr_data", bus.busW, mon_e.data);
                if (mon_e.at >= 0) chk("wr_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
        bus.ld_issue  = 1'b0; bus.ld_rd  = 5'd0;
        bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = 32'd0;
        bus.RX = 5'd0; bus.RY = 5'd0;

        // Reset values
        @(negedge clk);
        chk("rst_wen", {31'd0, bus.WEN}, 32'd0);
        chk("rst_rw", {27'd0, bus.RW}, 32'd0);
        chk("rst_busw", bus.busW, 32'd0);
        chk("rst_pending", bus.pending, 32'd0);
        chk("rst_cnt", {29'd0, bus.fifo_cnt}, 32'd0);
        chk("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("rst_err", {31'd0, bus.err_waw}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // ALU stream 3,5,7 back to back
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_0033;
        expect_wr(5'd3, 32'h0000_0033, cyc + 1);
        step();
        bus.alu_rd = 5'd5; bus.alu_data = 32'h0000_0055;
        expect_wr(5'd5, 32'h0000_0055, cyc + 1);
        step();
        bus.alu_rd = 5'd7; bus.alu_data = 32'h0000_0077;
        expect_wr(5'd7, 32'h0000_0077, cyc + 1);
        step();
        bus.alu_valid = 1'b0;
        step();
        @(negedge clk);
        chk("alu_idle_wen", {31'd0, bus.WEN}, 32'd0);
        chk("alu_idle_rw_hold", {27'd0, bus.RW}, 32'd7);

        // Load to r8, hazard until its return is written
        step();
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd8; bus.RX = 5'd8; bus.RY = 5'd9;
        step();
        bus.ld_issue = 1'b0;
        @(negedge clk);
        chk("ld8_pending", bus.pending, 32'h0000_0100);
        chk("ld8_stall_x", {31'd0, bus.stall_x}, 32'd1);
        chk("ld8_stall_y", {31'd0, bus.stall_y}, 32'd0);
        step();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd8; bus.mem_data = 32'hDEAD_BEEF;
        expect_wr(5'd8, 32'hDEAD_BEEF, cyc + 2);
        @(negedge clk);
        chk("ld8_ready", {31'd0, bus.mem_ready}, 32'd1);
        step();
        bus.mem_valid = 1'b0;
        @(negedge clk);
        chk("ld8_cnt1", {29'd0, bus.fifo_cnt}, 32'd1);
        chk("ld8_stall_hold", {31'd0, bus.stall_x}, 32'd1);
        step();
        @(negedge clk);
        chk("ld8_stall_release", {31'd0, bus.stall_x}, 32'd0);
        chk("ld8_pending_clear", bus.pending, 32'd0);

        // Return to r0 is accepted and dropped
        step();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h1234_5678;
        step();
        bus.mem_valid = 1'b0;
        @(negedge clk);
        chk("r0_drop_cnt", {29'd0, bus.fifo_cnt}, 32'd0);
        step();

        // Fill FIFO while ALU owns the port, fifth return held off
        for (int i = 0; i < 6; i++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h100 + i;
            expect_wr(5'd1, 32'h100 + i, cyc + 1);
            bus.mem_valid = 1'b1;
            bus.mem_rd    = (i < 4) ? 5'(10 + i) : 5'd14;
            bus.mem_data  = (i < 4) ? 32'hA0 + i : 32'hA4;
            if (i >= 4) begin
                @(negedge clk);
                chk("full_cnt", {29'd0, bus.fifo_cnt}, 32'd4);
                chk("full_ready", {31'd0, bus.mem_ready}, 32'd0);
            end
            step();
        end
        bus.alu_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ret_e[i].rd = 5'(10 + i);
            ret_e[i].data = 32'hA0 + i;
            expect_wr(ret_e[i].rd, ret_e[i].data, cyc + 1 + i);
        end
        @(negedge clk);
        chk("drain0_ready", {31'd0, bus.mem_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("drain1_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("drain1_cnt", {29'd0, bus.fifo_cnt}, 32'd3);
        step();
        bus.mem_valid = 1'b0;
        @(negedge clk);
        chk("drain2_cnt", {29'd0, bus.fifo_cnt}, 32'd3);
        repeat (5) step();
        @(negedge clk);
        chk("drain_done_cnt", {29'd0, bus.fifo_cnt}, 32'd0);

        // Reissue of r9 in the same cycle its return is popped
        step();
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd9;
        step();
        bus.ld_issue = 1'b0;
        step();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h0000_0999;
        expect_wr(5'd9, 32'h0000_0999, cyc + 2);
        step();
        bus.mem_valid = 1'b0;
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd9;
        step();
        bus.ld_issue = 1'b0; bus.RY = 5'd9;
        @(negedge clk);
        chk("setwin_pending", bus.pending, 32'h0000_0200);
        chk("setwin_stall_y", {31'd0, bus.stall_y}, 32'd1);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h0000_099A;
        expect_wr(5'd9, 32'h0000_099A, cyc + 2);
        step();
        bus.mem_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("r9_pending_clear", bus.pending, 32'd0);
        chk("r9_stall_clear", {31'd0, bus.stall_y}, 32'd0);

        // Load to r0 never marks a hazard
        step();
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd0; bus.RX = 5'd0;
        step();
        bus.ld_issue = 1'b0;
        @(negedge clk);
        chk("ld0_pending", bus.pending, 32'd0);
        chk("ld0_stall_x", {31'd0, bus.stall_x}, 32'd0);

        // WAW: ALU writes r4 while its load is outstanding
        step();
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd4;
        step();
        bus.ld_issue = 1'b0;
        @(negedge clk);
        chk("waw_err_before", {31'd0, bus.err_waw}, 32'd0);
        step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h0000_0444;
        expect_wr(5'd4, 32'h0000_0444, cyc + 1);
        step();
        bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("waw_err_set", {31'd0, bus.err_waw}, 32'd1);
        chk("waw_pending_kept", bus.pending, 32'h0000_0010);
        repeat (3) step();
        @(negedge clk);
        chk("waw_err_sticky", {31'd0, bus.err_waw}, 32'd1);

        // Reset with three returns buffered
        step();
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h200 + i;
            if (i < 2) expect_wr(5'd2, 32'h200 + i, cyc + 1);
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(11 + i); bus.mem_data = 32'hB0 + i;
            bus.ld_issue = (i == 0); bus.ld_rd = 5'd11;
            step();
        end
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.ld_issue = 1'b0;
        chk("prerst_cnt", {29'd0, bus.fifo_cnt}, 32'd3);
        chk("prerst_pending", bus.pending, 32'h0000_0810);
        rst = 1'b1;
        #1;
        chk("midrst_wen", {31'd0, bus.WEN}, 32'd0);
        chk("midrst_cnt", {29'd0, bus.fifo_cnt}, 32'd0);
        chk("midrst_pending", bus.pending, 32'd0);
        chk("midrst_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("midrst_err", {31'd0, bus.err_waw}, 32'd0);
        chk("midrst_busw", bus.busW, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        chk("postrst_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("postrst_cnt", {29'd0, bus.fifo_cnt}, 32'd0);
        repeat (6) step();
        @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
